// File: rtl/pipeline_pkg.sv
// Shared pipeline types: hazard FSM states, forward selects and register address helpers.
package pipeline_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int STALL_CNT_W   = 2;
  localparam int STALL_COUNT_W = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hazardState_t;

  typedef enum logic [1:0] {
    FWD_REGFILE   = 2'b00,
    FWD_WRITEBACK = 2'b01,
    FWD_MEMORY    = 2'b10
  } forwardSel_t;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic addrHit(input logic [REG_ADDR_W-1:0] src,
                                   input logic [REG_ADDR_W-1:0] dst,
                                   input logic                  writeEn);
    return writeEn && (src != '0) && (src == dst);
  endfunction

  function automatic forwardSel_t selectForward(input logic [REG_ADDR_W-1:0] src,
                                                input logic [REG_ADDR_W-1:0] memReg,
                                                input logic                  memWe,
                                                input logic [REG_ADDR_W-1:0] wbReg,
                                                input logic                  wbWe);
    if (addrHit(src, memReg, memWe)) return FWD_MEMORY;
    if (addrHit(src, wbReg, wbWe))   return FWD_WRITEBACK;
    return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Execute-stage operand bypass select; the younger Memory result wins over Writeback.
module forwarding_unit
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rsExecute,
  input  logic [REG_ADDR_W-1:0] rtExecute,
  input  logic [REG_ADDR_W-1:0] writeRegMemory,
  input  logic                  regWriteMemory,
  input  logic [REG_ADDR_W-1:0] writeRegWriteback,
  input  logic                  regWriteWriteback,
  output logic [1:0]            forwardA,
  output logic [1:0]            forwardB
);

  logic [1:0][REG_ADDR_W-1:0] srcBus;
  logic [1:0][1:0]            selBus;

  assign srcBus = {rtExecute, rsExecute};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gOperand
      assign selBus[gi] = selectForward(srcBus[gi], writeRegMemory, regWriteMemory,
                                        writeRegWriteback, regWriteWriteback);
    end
  endgenerate

  assign forwardA = selBus[0];
  assign forwardB = selBus[1];

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush/forward control. Define FORWARDING_EN to enable bypassing,
// which reduces stalls to the single load-use bubble.
module hazard_controller
  import pipeline_pkg::*;
(
  input  logic                  clockMachine,
  input  logic                  resetMachine,
  input  logic [REG_ADDR_W-1:0] rsDecode,
  input  logic [REG_ADDR_W-1:0] rtDecode,
  input  logic [REG_ADDR_W-1:0] rsExecute,
  input  logic [REG_ADDR_W-1:0] rtExecute,
  input  logic [REG_ADDR_W-1:0] writeRegExecute,
  input  logic                  regWriteExecute,
  input  logic                  memReadExecute,
  input  logic [REG_ADDR_W-1:0] writeRegMemory,
  input  logic                  regWriteMemory,
  input  logic [REG_ADDR_W-1:0] writeRegWriteback,
  input  logic                  regWriteWriteback,
  input  logic                  branchTakenExecute,
  input  logic                  jumpDecode,
  output logic                  stallFetch,
  output logic                  stallDecode,
  output logic                  flushDecode,
  output logic                  flushExecute,
  output logic [1:0]            forwardA,
  output logic [1:0]            forwardB,
  output logic [15:0]           stallCount
);

  hazardState_t           stateReg, stateNext;
  logic [STALL_CNT_W-1:0] cntReg, cntNext;
  logic [STALL_COUNT_W-1:0] stallCountReg;
  logic                   hazard;
  logic [STALL_CNT_W-1:0] stallNeed;
  logic                   stallInt, flushDecodeInt, flushExecuteInt;
  logic [1:0]             fwdA, fwdB;
  logic                   unusedInputs;

`ifdef FORWARDING_EN
  // Only a load still in Execute cannot be bypassed in time.
  assign hazard    = memReadExecute &&
                     (addrHit(rsDecode, writeRegExecute, 1'b1) ||
                      addrHit(rtDecode, writeRegExecute, 1'b1));
  assign stallNeed = 2'd1;
  assign unusedInputs = regWriteExecute;

  forwarding_unit uForward (
    .rsExecute         (rsExecute),
    .rtExecute         (rtExecute),
    .writeRegMemory    (writeRegMemory),
    .regWriteMemory    (regWriteMemory),
    .writeRegWriteback (writeRegWriteback),
    .regWriteWriteback (regWriteWriteback),
    .forwardA          (fwdA),
    .forwardB          (fwdB)
  );
`else
  logic exHit, memHit;

  assign exHit     = addrHit(rsDecode, writeRegExecute, regWriteExecute) ||
                     addrHit(rtDecode, writeRegExecute, regWriteExecute);
  assign memHit    = addrHit(rsDecode, writeRegMemory, regWriteMemory) ||
                     addrHit(rtDecode, writeRegMemory, regWriteMemory);
  assign hazard    = exHit || memHit;
  assign stallNeed = exHit ? 2'd2 : 2'd1;
  assign fwdA      = FWD_REGFILE;
  assign fwdB      = FWD_REGFILE;
  assign unusedInputs = ^{rsExecute, rtExecute, writeRegWriteback, regWriteWriteback, memReadExecute};
`endif

  always_ff @(posedge clockMachine) begin
    if (resetMachine) begin
      stateReg      <= RUN;
      cntReg        <= '0;
      stallCountReg <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      if (stallInt && (stallCountReg != '1))
        stallCountReg <= stallCountReg + 16'd1;
    end
  end

  // The detecting cycle already stalls once, so STALL only holds the remaining cycles.
  always_comb begin
    stateNext       = stateReg;
    cntNext         = cntReg;
    stallInt        = 1'b0;
    flushDecodeInt  = 1'b0;
    flushExecuteInt = 1'b0;
    if (branchTakenExecute) begin
      flushDecodeInt  = 1'b1;
      flushExecuteInt = 1'b1;
      cntNext         = '0;
      stateNext       = FLUSH;
    end else begin
      unique case (stateReg)
        RUN: begin
          if (hazard) begin
            stallInt        = 1'b1;
            flushExecuteInt = 1'b1;
            cntNext         = stallNeed - 2'd1;
            if (stallNeed > 2'd1) stateNext = STALL;
          end else if (jumpDecode) begin
            flushDecodeInt = 1'b1;
          end
        end
        STALL: begin
          stallInt        = 1'b1;
          flushExecuteInt = 1'b1;
          if (cntReg > 2'd1) begin
            cntNext = cntReg - 2'd1;
          end else if (hazard && (stallNeed > 2'd1)) begin
            cntNext = stallNeed - 2'd1;
          end else begin
            cntNext   = '0;
            stateNext = RUN;
          end
        end
        FLUSH: begin
          stateNext = RUN;
        end
        default: begin
          cntNext   = '0;
          stateNext = RUN;
        end
      endcase
    end
  end

  assign stallFetch   = !resetMachine && stallInt;
  assign stallDecode  = !resetMachine && stallInt;
  assign flushDecode  = !resetMachine && flushDecodeInt;
  assign flushExecute = !resetMachine && flushExecuteInt;
  assign forwardA     = resetMachine ? 2'b00 : fwdA;
  assign forwardB     = resetMachine ? 2'b00 : fwdB;
  assign stallCount   = resetMachine ? 16'd0 : stallCountReg;

endmodule
